// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings, pipeline register layouts and ALU/immediate helpers for the RV32I datapath.
package riscv_pkg;
  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W = 2'b01;
  localparam logic [1:0] FWD_M = 2'b10;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } fd_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } de_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } em_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } mw_t;

  function automatic logic [31:0] alu(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
    return ctl == ALU_SUB ? a - b :
           ctl == ALU_AND ? a & b :
           ctl == ALU_OR  ? a | b :
           ctl == ALU_SLT ? {31'd0, $signed(a) < $signed(b)} : a + b;
  endfunction

  function automatic logic [31:0] extend(input logic [31:7] i, input logic [1:0] s);
    return s == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
           s == IMM_B ? {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0} :
           s == IMM_J ? {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0} :
                        {{20{i[31]}}, i[31:20]};
  endfunction
endpackage

// File: rtl/hazard_unit.sv
// hazard_unit: E-stage forwarding selects plus F/D stall and D/E flush for the five-stage pipeline.
module hazard_unit
  import riscv_pkg::*;
#(
  parameter bit FORWARD_EN = 1'b1
) (
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic [4:0] rd_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_e,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic [1:0] result_src_e,
  input  logic       pc_src_e,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e
);
  logic raw;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wm, input logic [4:0] rm,
                                         input logic ww, input logic [4:0] rw);
    return !FORWARD_EN ? FWD_NONE :
           (wm && rm != 5'd0 && rm == rs) ? FWD_M :
           (ww && rw != 5'd0 && rw == rs) ? FWD_W : FWD_NONE;
  endfunction

  function automatic logic hit(input logic we, input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    return we && rd != 5'd0 && (rd == a || rd == b);
  endfunction

  always_comb begin
    fwd_a_e = fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
    fwd_b_e = fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);
    raw = FORWARD_EN ? hit(result_src_e == RESULT_MEM, rd_e, rs1_d, rs2_d)
                     : hit(reg_write_e, rd_e, rs1_d, rs2_d) | hit(reg_write_m, rd_m, rs1_d, rs2_d) |
                       hit(reg_write_w, rd_w, rs1_d, rs2_d);
    // a taken branch/jump overrides the hold so fetch redirects immediately
    stall_f = raw & ~pc_src_e;
    stall_d = raw & ~pc_src_e;
    flush_d = pc_src_e;
    flush_e = raw | pc_src_e;
  end
endmodule

// File: rtl/pipelined_datapath.sv
// pipelined_datapath: five-stage RV32I integer datapath with forwarding, load-use stall and branch/jump flush.
module pipelined_datapath
  import riscv_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter bit              FORWARD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] instr_f,
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] instr_d,
  input  logic            reg_write_d,
  input  logic [1:0]      result_src_d,
  input  logic            mem_write_d,
  input  logic            jump_d,
  input  logic            branch_d,
  input  logic [2:0]      alu_control_d,
  input  logic            alu_src_d,
  input  logic [1:0]      imm_src_d,
  output logic            mem_write_m,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  input  logic [XLEN-1:0] read_data_m,
  output logic            stall_o
);
  logic [XLEN-1:0] pc_q, pc_d, pc4_f;
  fd_t fd_q, fd_d;
  de_t de_q, de_d;
  em_t em_q, em_d;
  mw_t mw_q, mw_d;
  logic [31:0] rf [0:31];
  logic [31:0] result_w, src_a, fwd_b_val, src_b, alu_y, pc_target, rd1, rd2;
  logic [4:0] rs1_d, rs2_d;
  logic [1:0] fwd_a, fwd_b;
  logic stall_f, stall_d, flush_d, flush_e, pc_src;

  hazard_unit #(.FORWARD_EN(FORWARD_EN)) u_hazard (
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(de_q.rs1), .rs2_e(de_q.rs2),
    .rd_e(de_q.rd), .rd_m(em_q.rd), .rd_w(mw_q.rd),
    .reg_write_e(de_q.ctrl.reg_write), .reg_write_m(em_q.reg_write), .reg_write_w(mw_q.reg_write),
    .result_src_e(de_q.ctrl.result_src), .pc_src_e(pc_src),
    .fwd_a_e(fwd_a), .fwd_b_e(fwd_b),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e)
  );

  always_comb begin
    pc4_f = pc_q + 32'd4;
    result_w = mw_q.result_src == RESULT_MEM ? mw_q.read_data :
               mw_q.result_src == RESULT_PC4 ? mw_q.pc4 : mw_q.alu_result;
    src_a = fwd_a == FWD_M ? em_q.alu_result : fwd_a == FWD_W ? result_w : de_q.rd1;
    fwd_b_val = fwd_b == FWD_M ? em_q.alu_result : fwd_b == FWD_W ? result_w : de_q.rd2;
    src_b = de_q.ctrl.alu_src ? de_q.imm : fwd_b_val;
    alu_y = alu(de_q.ctrl.alu_control, src_a, src_b);
    pc_target = de_q.pc + de_q.imm;
    pc_src = de_q.ctrl.jump | (de_q.ctrl.branch & (alu_y == 32'd0));
    pc_d = pc_src ? pc_target : stall_f ? pc_q : pc4_f;
    rs1_d = fd_q.instr[19:15];
    rs2_d = fd_q.instr[24:20];
    // write-first: a W-stage write to the register being read is visible in D this cycle
    rd1 = rs1_d == 5'd0 ? 32'd0 : (mw_q.reg_write && mw_q.rd == rs1_d) ? result_w : rf[rs1_d];
    rd2 = rs2_d == 5'd0 ? 32'd0 : (mw_q.reg_write && mw_q.rd == rs2_d) ? result_w : rf[rs2_d];
    fd_d = flush_d ? '{instr: NOP_INSTR, pc: 32'd0, pc4: 32'd0} :
           stall_d ? fd_q : '{instr: instr_f, pc: pc_q, pc4: pc4_f};
    de_d = flush_e ? '0 : '{
      ctrl: '{reg_write: reg_write_d, result_src: result_src_d, mem_write: mem_write_d, jump: jump_d,
              branch: branch_d, alu_control: alu_control_d, alu_src: alu_src_d},
      rd1: rd1, rd2: rd2, pc: fd_q.pc, imm: extend(fd_q.instr[31:7], imm_src_d), pc4: fd_q.pc4,
      rs1: rs1_d, rs2: rs2_d, rd: fd_q.instr[11:7]};
    em_d = '{reg_write: de_q.ctrl.reg_write, result_src: de_q.ctrl.result_src, mem_write: de_q.ctrl.mem_write,
             alu_result: alu_y, write_data: fwd_b_val, pc4: de_q.pc4, rd: de_q.rd};
    mw_d = '{reg_write: em_q.reg_write, result_src: em_q.result_src, alu_result: em_q.alu_result,
             read_data: read_data_m, pc4: em_q.pc4, rd: em_q.rd};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      fd_q <= '{instr: NOP_INSTR, pc: 32'd0, pc4: 32'd0};
      de_q <= '0;
      em_q <= '0;
      mw_q <= '0;
    end else begin
      pc_q <= pc_d;
      fd_q <= fd_d;
      de_q <= de_d;
      em_q <= em_d;
      mw_q <= mw_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mw_q.reg_write && mw_q.rd != 5'd0) rf[mw_q.rd] <= result_w;
  end

  assign pc_f = pc_q;
  assign instr_d = fd_q.instr;
  assign mem_write_m = em_q.mem_write;
  assign alu_result_m = em_q.alu_result;
  assign write_data_m = em_q.write_data;
  assign stall_o = stall_f;
endmodule

// File: tb/tb_pipelined_datapath.sv
// tb_pipelined_datapath: directed programs on a forwarding and a non-forwarding instance, checked via stores and stalls.
module tb_pipelined_datapath;
  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       j;
    logic       b;
    logic [2:0] ac;
    logic       as;
    logic [1:0] is;
  } ctl_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] imem [64];
  logic [31:0] pc0, pc1, id0, id1, ar0, ar1, wd0, wd1;
  logic mw0, mw1, stall0, stall1;
  ctl_t c0, c1;
  int checks = 0, passed = 0;
  int cyc, s0, s1, st0, st1;
  logic [31:0] a0, d0, a1, d1;
  logic [31:0] pc_log [16];

  always #5 clk = ~clk;

  function automatic ctl_t dec(input logic [31:0] i);
    ctl_t c;
    c = '0;
    case (i[6:0])
      7'h13: begin c.rw = 1; c.as = 1; end
      7'h33: begin c.rw = 1; c.ac = i[30] ? 3'b001 : 3'b000; end
      7'h03: begin c.rw = 1; c.rs = 2'b01; c.as = 1; end
      7'h23: begin c.mw = 1; c.as = 1; c.is = 2'b01; end
      7'h63: begin c.b = 1; c.is = 2'b10; c.ac = 3'b001; end
      7'h6f: begin c.j = 1; c.rw = 1; c.rs = 2'b10; c.is = 2'b11; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] e_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction
  function automatic logic [31:0] e_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction
  function automatic logic [31:0] e_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'h03};
  endfunction
  function automatic logic [31:0] e_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] e_beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] off);
    return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'h63};
  endfunction

  assign c0 = dec(id0);
  assign c1 = dec(id1);

  pipelined_datapath #(.XLEN(32), .RESET_PC(32'h0), .FORWARD_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .instr_f(imem[pc0[7:2]]), .pc_f(pc0), .instr_d(id0),
    .reg_write_d(c0.rw), .result_src_d(c0.rs), .mem_write_d(c0.mw), .jump_d(c0.j), .branch_d(c0.b),
    .alu_control_d(c0.ac), .alu_src_d(c0.as), .imm_src_d(c0.is),
    .mem_write_m(mw0), .alu_result_m(ar0), .write_data_m(wd0), .read_data_m(32'h0000_1234), .stall_o(stall0)
  );

  pipelined_datapath #(.XLEN(32), .RESET_PC(32'h0), .FORWARD_EN(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .instr_f(imem[pc1[7:2]]), .pc_f(pc1), .instr_d(id1),
    .reg_write_d(c1.rw), .result_src_d(c1.rs), .mem_write_d(c1.mw), .jump_d(c1.j), .branch_d(c1.b),
    .alu_control_d(c1.ac), .alu_src_d(c1.as), .imm_src_d(c1.is),
    .mem_write_m(mw1), .alu_result_m(ar1), .write_data_m(wd1), .read_data_m(32'h0000_1234), .stall_o(stall1)
  );

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc = 0; s0 = 0; s1 = 0; st0 = 0; st1 = 0;
    a0 = '0; d0 = '0; a1 = '0; d1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (cyc < 16) pc_log[cyc] = pc0;
      cyc++;
      if (stall0) s0++;
      if (stall1) s1++;
      if (mw0) begin st0++; if (st0 == 1) begin a0 = ar0; d0 = wd0; end end
      if (mw1) begin st1++; if (st1 == 1) begin a1 = ar1; d1 = wd1; end end
    end
  endtask

  task automatic test_reset();
    clear_prog();
    imem[0] = e_addi(5'd1, 5'd0, 12'd5);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pc0 !== 32'h0) $display("FAIL reset_pc got %h want 00000000", pc0); else passed++;
    checks++; if (id0 !== 32'h0000_0013) $display("FAIL reset_instr_d got %h want 00000013", id0); else passed++;
    checks++; if (mw0 !== 1'b0) $display("FAIL reset_mem_write got %b want 0", mw0); else passed++;
    checks++; if (stall0 !== 1'b0) $display("FAIL reset_stall got %b want 0", stall0); else passed++;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (pc0 !== 32'h4) $display("FAIL first_fetch_pc got %h want 00000004", pc0); else passed++;
    checks++; if (id0 !== 32'h0050_0093) $display("FAIL first_fetch_instr got %h want 00500093", id0); else passed++;
  endtask

  task automatic test_ex_forward();
    clear_prog();
    imem[0] = e_addi(5'd1, 5'd0, 12'd5);
    imem[1] = e_add(5'd2, 5'd1, 5'd1);
    imem[5] = e_sw(5'd2, 5'd0, 12'd0);
    do_reset();
    cycles(20);
    checks++; if (st0 !== 1) $display("FAIL exfwd_stores got %0d want 1", st0); else passed++;
    checks++; if (d0 !== 32'd10) $display("FAIL exfwd_x2 got %0d want 10", d0); else passed++;
    checks++; if (s0 !== 0) $display("FAIL exfwd_stalls got %0d want 0", s0); else passed++;
    checks++; if (d1 !== 32'd10) $display("FAIL nofwd_x2 got %0d want 10", d1); else passed++;
    checks++; if (s1 !== 3) $display("FAIL nofwd_stalls got %0d want 3", s1); else passed++;
  endtask

  task automatic test_wb_forward();
    clear_prog();
    imem[0] = e_addi(5'd1, 5'd0, 12'd5);
    imem[2] = e_add(5'd2, 5'd1, 5'd1);
    imem[3] = e_sw(5'd2, 5'd0, 12'd0);
    do_reset();
    cycles(20);
    checks++; if (d0 !== 32'd10) $display("FAIL wbfwd_x2 got %0d want 10", d0); else passed++;
    checks++; if (s0 !== 0) $display("FAIL wbfwd_stalls got %0d want 0", s0); else passed++;
  endtask

  task automatic test_load_use();
    clear_prog();
    imem[0] = e_lw(5'd3, 5'd0, 12'd0);
    imem[1] = e_add(5'd4, 5'd3, 5'd3);
    imem[2] = e_sw(5'd4, 5'd0, 12'd0);
    do_reset();
    cycles(20);
    checks++; if (d0 !== 32'h2468) $display("FAIL loaduse_x4 got %h want 00002468", d0); else passed++;
    checks++; if (s0 !== 1) $display("FAIL loaduse_stalls got %0d want 1", s0); else passed++;
  endtask

  task automatic test_branch_flush();
    clear_prog();
    imem[0] = e_addi(5'd1, 5'd0, 12'd1);
    imem[1] = e_beq(5'd0, 5'd0, 13'd8);
    imem[2] = e_addi(5'd1, 5'd0, 12'd2);
    imem[3] = e_sw(5'd1, 5'd0, 12'd0);
    do_reset();
    cycles(20);
    checks++; if (st0 !== 1) $display("FAIL branch_stores got %0d want 1", st0); else passed++;
    checks++; if (d0 !== 32'd1) $display("FAIL branch_x1 got %0d want 1", d0); else passed++;
    checks++; if (pc_log[3] !== 32'd12) $display("FAIL branch_target_pc got %h want 0000000c", pc_log[3]); else passed++;
    checks++; if (pc_log[4] !== 32'd16) $display("FAIL branch_after_pc got %h want 00000010", pc_log[4]); else passed++;
  endtask

  task automatic test_x0_hazard();
    clear_prog();
    imem[0] = e_addi(5'd0, 5'd0, 12'd7);
    imem[1] = e_add(5'd5, 5'd0, 5'd0);
    imem[2] = e_sw(5'd5, 5'd0, 12'd4);
    do_reset();
    cycles(20);
    checks++; if (d0 !== 32'd0) $display("FAIL x0_x5 got %0d want 0", d0); else passed++;
    checks++; if (a0 !== 32'd4) $display("FAIL x0_addr got %0d want 4", a0); else passed++;
    checks++; if (s0 !== 0) $display("FAIL x0_stalls got %0d want 0", s0); else passed++;
  endtask

  task automatic test_back_to_back();
    clear_prog();
    imem[0] = e_addi(5'd1, 5'd0, 12'd3);
    imem[1] = e_addi(5'd1, 5'd1, 12'd4);
    imem[2] = e_addi(5'd1, 5'd1, 12'd5);
    imem[3] = e_sw(5'd1, 5'd0, 12'd8);
    do_reset();
    cycles(20);
    checks++; if (d0 !== 32'd12) $display("FAIL b2b_x1 got %0d want 12", d0); else passed++;
    checks++; if (a0 !== 32'd8) $display("FAIL b2b_addr got %0d want 8", a0); else passed++;
  endtask

  task automatic test_mid_reset();
    clear_prog();
    imem[0] = e_addi(5'd6, 5'd0, 12'd9);
    imem[1] = e_sw(5'd6, 5'd0, 12'd12);
    do_reset();
    cycles(3);
    reset = 1'b0;
    #1;
    checks++; if (pc0 !== 32'h0) $display("FAIL midreset_pc got %h want 00000000", pc0); else passed++;
    checks++; if (id0 !== 32'h0000_0013) $display("FAIL midreset_instr_d got %h want 00000013", id0); else passed++;
    cycles(2);
    checks++; if (st0 !== 0) $display("FAIL midreset_stores got %0d want 0", st0); else passed++;
    reset = 1'b1;
    cycles(12);
    checks++; if (st0 !== 1) $display("FAIL midreset_rerun_stores got %0d want 1", st0); else passed++;
    checks++; if (d0 !== 32'd9) $display("FAIL midreset_x6 got %0d want 9", d0); else passed++;
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_wb_forward();
    test_load_use();
    test_branch_flush();
    test_x0_hazard();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
